room_game_scheduler: RTL
========================

ROOM_GAME_SCHEDULER -- requirements
Module: room_game_scheduler

Interface
REQ-001 Parameter: TICK_DIV, default 6250, clock cycles per navigation tick (1 ms at 6.25 MHz).
REQ-002 Port: clock  in  1  system clock, 6.25 MHz.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: enable  in  1  game-enable switch; navigation is frozen when low.
REQ-005 Port: btn_pulse  in  5  single-cycle button pulses, order {L,U,D,R,C}.
REQ-006 Port: game_done  in  4  level from each minigame, order {left,top,bottom,right}.
REQ-007 Port: game_lose  in  4  level from each minigame, same order.
REQ-008 Port: game_start  out  4  one-hot-or-zero start level to each minigame.
REQ-009 Port: room  out  3  current room: CENTER=0, LEFT=1, TOP=2, BOTTOM=3, RIGHT=4.
REQ-010 Port: owner  out  3  display and 7-segment owner: ROOM=0, GAME_L=1, GAME_T=2, GAME_B=3, GAME_R=4, LOSE=5, WIN=6.
REQ-011 Port: cleared  out  4  sticky per-room cleared flags, same order as game_done.

Function
REQ-012 A free-running counter SHALL produce a one-cycle tick every TICK_DIV cycles, wrapping from TICK_DIV-1 to 0.
REQ-013 Each btn_pulse bit SHALL set a pending latch; all latches SHALL clear on the tick cycle, including a pulse that arrives on the tick cycle itself.
REQ-014 Navigation SHALL evaluate pending buttons only on tick with enable=1; with enable=0 the tick still clears the latches and makes no state change.
REQ-015 When several buttons are pending, priority SHALL be L>U>D>R>C, and only the winner acts.
REQ-016 FSM states: NAV, PLAY, LOST, WON; outputs SHALL be registered and update the cycle after the deciding edge.
REQ-017 In NAV at CENTER: L/U/D/R SHALL move to LEFT/TOP/BOTTOM/RIGHT respectively.
REQ-018 In NAV at CENTER: C SHALL enter WON if cleared==4'b1111; otherwise C does nothing.
REQ-019 In NAV at an outer room: the direction back toward centre (LEFT:R, TOP:D, BOTTOM:U, RIGHT:L) SHALL return to CENTER.
REQ-020 In NAV at an outer room: the outward direction (LEFT:L, TOP:U, BOTTOM:D, RIGHT:R) SHALL enter PLAY only if that room's cleared bit is 0.
REQ-021 In PLAY, game_start SHALL hold that room's bit high and owner SHALL equal that room's GAME code.
REQ-022 PLAY SHALL sample game_done and game_lose every cycle, not only on tick; buttons have no effect in PLAY.
REQ-023 PLAY, game_lose high -> LOST; this SHALL take precedence over a simultaneous game_done.
REQ-024 PLAY, game_done high -> set the cleared bit, drop game_start, return to NAV in the same room.
REQ-025 done/lose bits of non-active games SHALL be ignored.
REQ-026 LOST: owner=LOSE, game_start=0; a tick with enable=1 and C pending SHALL return to NAV at CENTER with cleared=0.
REQ-027 WON: owner=WIN; C on tick SHALL return to NAV at CENTER with cleared=0.
REQ-028 In NAV, owner SHALL be ROOM, or WIN when the state is WON; game_start SHALL be 0 outside PLAY.

Reset
REQ-029 Reset SHALL force state=NAV, room=CENTER, owner=ROOM, game_start=0, cleared=0, tick counter=0 and pending latches=0 on the next edge, and SHALL override all other inputs, including mid-PLAY.

Structure
REQ-030 Room codes, owner codes, FSM state encoding and the TICK_DIV default SHALL live in shared package dungeon_pkg.
REQ-031 The tick counter SHALL be a sub-module tick_gen (parameter TICK_DIV, output tick); everything else SHALL be flat.

Verification
REQ-032 TICK_DIV=8; U pulse at CENTER -> room=2 one cycle after the next tick; second U -> game_start=4'b0100 and owner=2.
REQ-033 In TOP PLAY, game_done[2]=1 -> next cycle game_start=0, cleared=4'b0100, room=2; a further U does not restart the game.
REQ-034 In PLAY, game_lose and game_done asserted on the same cycle -> owner=5 and cleared unchanged; C then returns room=0 with cleared=0.
REQ-035 Clear all four rooms, then C at CENTER -> owner=6; C at CENTER with cleared=4'b1011 -> no change.
REQ-036 L and R pulsed in the same tick window at CENTER -> room=1; enable=0 with U pending -> no change and the latch is cleared.
REQ-037 Reset asserted mid-PLAY -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/dungeon_pkg.sv
// Shared codes for the room/minigame dungeon: rooms, display owners, FSM states, button decode.
package dungeon_pkg;

  localparam int unsigned TICK_DIV_DEFAULT = 6250;

  typedef enum logic [2:0] {
    ROOM_CENTER = 3'd0,
    ROOM_LEFT   = 3'd1,
    ROOM_TOP    = 3'd2,
    ROOM_BOTTOM = 3'd3,
    ROOM_RIGHT  = 3'd4
  } room_e;

  typedef enum logic [2:0] {
    OWN_ROOM   = 3'd0,
    OWN_GAME_L = 3'd1,
    OWN_GAME_T = 3'd2,
    OWN_GAME_B = 3'd3,
    OWN_GAME_R = 3'd4,
    OWN_LOSE   = 3'd5,
    OWN_WIN    = 3'd6
  } owner_e;

  typedef enum logic [1:0] {
    ST_NAV  = 2'd0,
    ST_PLAY = 2'd1,
    ST_LOST = 2'd2,
    ST_WON  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    BTN_NONE = 3'd0,
    BTN_L    = 3'd1,
    BTN_U    = 3'd2,
    BTN_D    = 3'd3,
    BTN_R    = 3'd4,
    BTN_C    = 3'd5
  } btn_e;

  // Pending buttons arrive as {L,U,D,R,C}; L has highest priority.
  function automatic btn_e btn_winner(input logic [4:0] p);
    if (p[4])      return BTN_L;
    else if (p[3]) return BTN_U;
    else if (p[2]) return BTN_D;
    else if (p[1]) return BTN_R;
    else if (p[0]) return BTN_C;
    else           return BTN_NONE;
  endfunction

  // Bit position of a room inside the {left,top,bottom,right} game vectors.
  function automatic logic [1:0] room_bit(input room_e r);
    case (r)
      ROOM_LEFT:   return 2'd3;
      ROOM_TOP:    return 2'd2;
      ROOM_BOTTOM: return 2'd1;
      default:     return 2'd0;
    endcase
  endfunction

  // Button pointing back toward the centre from an outer room.
  function automatic btn_e back_btn(input room_e r);
    case (r)
      ROOM_LEFT:   return BTN_R;
      ROOM_TOP:    return BTN_D;
      ROOM_BOTTOM: return BTN_U;
      ROOM_RIGHT:  return BTN_L;
      default:     return BTN_NONE;
    endcase
  endfunction

  // Button pointing away from the centre, which launches that room's game.
  function automatic btn_e outward_btn(input room_e r);
    case (r)
      ROOM_LEFT:   return BTN_L;
      ROOM_TOP:    return BTN_U;
      ROOM_BOTTOM: return BTN_D;
      ROOM_RIGHT:  return BTN_R;
      default:     return BTN_NONE;
    endcase
  endfunction

  // Display owner code for the game hosted in a room.
  function automatic owner_e game_owner(input room_e r);
    case (r)
      ROOM_LEFT:   return OWN_GAME_L;
      ROOM_TOP:    return OWN_GAME_T;
      ROOM_BOTTOM: return OWN_GAME_B;
      ROOM_RIGHT:  return OWN_GAME_R;
      default:     return OWN_ROOM;
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle navigation tick every TICK_DIV clocks.
module tick_gen
  import dungeon_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] count;

  // Count 0..TICK_DIV-1; the registered tick rises on the wrap back to 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (count == CW'(TICK_DIV - 1)) begin
      count <= '0;
      tick  <= 1'b1;
    end else begin
      count <= count + CW'(1);
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/room_game_scheduler.sv
// Dungeon navigator: moves between rooms on ticks, launches minigames and tracks win/lose.
module room_game_scheduler
  import dungeon_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [4:0] btn_pulse,
  input  logic [3:0] game_done,
  input  logic [3:0] game_lose,
  output logic [3:0] game_start,
  output logic [2:0] room,
  output logic [2:0] owner,
  output logic [3:0] cleared
);

  logic       tick;
  logic [4:0] pending;
  btn_e       win;
  logic       act;
  logic [1:0] idx;
  state_e     state;
  room_e      room_q;
  owner_e     owner_q;
  logic [3:0] start_q;
  logic [3:0] cleared_q;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  // Button latches collect pulses between ticks; the tick empties them unconditionally.
  always_ff @(posedge clock) begin
    if (reset || tick) pending <= '0;
    else               pending <= pending | btn_pulse;
  end

  assign win = btn_winner(pending);
  assign act = tick & enable;
  assign idx = room_bit(room_q);

  // Game FSM; every output is a register updated alongside the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_NAV;
      room_q    <= ROOM_CENTER;
      owner_q   <= OWN_ROOM;
      start_q   <= '0;
      cleared_q <= '0;
    end else begin
      case (state)
        ST_NAV: begin
          if (act) begin
            if (room_q == ROOM_CENTER) begin
              case (win)
                BTN_L: room_q <= ROOM_LEFT;
                BTN_U: room_q <= ROOM_TOP;
                BTN_D: room_q <= ROOM_BOTTOM;
                BTN_R: room_q <= ROOM_RIGHT;
                BTN_C: begin
                  if (&cleared_q) begin
                    state   <= ST_WON;
                    owner_q <= OWN_WIN;
                  end
                end
                default: ;
              endcase
            end else if (win == back_btn(room_q)) begin
              room_q <= ROOM_CENTER;
            end else if (win == outward_btn(room_q) && !cleared_q[idx]) begin
              state   <= ST_PLAY;
              owner_q <= game_owner(room_q);
              start_q <= 4'b0001 << idx;
            end
          end
        end
        ST_PLAY: begin
          // Only the active game's flags matter; losing beats finishing.
          if (game_lose[idx]) begin
            state   <= ST_LOST;
            owner_q <= OWN_LOSE;
            start_q <= '0;
          end else if (game_done[idx]) begin
            state          <= ST_NAV;
            owner_q        <= OWN_ROOM;
            start_q        <= '0;
            cleared_q[idx] <= 1'b1;
          end
        end
        ST_LOST, ST_WON: begin
          if (act && win == BTN_C) begin
            state     <= ST_NAV;
            room_q    <= ROOM_CENTER;
            owner_q   <= OWN_ROOM;
            cleared_q <= '0;
          end
        end
        default: state <= ST_NAV;
      endcase
    end
  end

  assign room       = room_q;
  assign owner      = owner_q;
  assign game_start = start_q;
  assign cleared    = cleared_q;

endmodule
